// File: rtl/axis_width_pkg.sv
// Shared types, width helpers and reset constants for the AXI-Stream width upsizer.
package axis_width_pkg;

    // Lane index wide enough for any supported ratio (up to 256 lanes).
    localparam int LANE_IDX_W = 8;
    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    // Reset values for the output holding register.
    localparam logic OUT_VALID_RST = 1'b0;
    localparam logic OUT_FIELD_RST = 1'b0;

    // Wide-side data width in bits.
    function automatic int calc_m_data_w(input int s_data_w, input int ratio);
        return s_data_w * ratio;
    endfunction

    // Wide-side byte-qualifier width.
    function automatic int calc_m_bw(input int s_data_w, input int ratio);
        return (s_data_w * ratio) / 8;
    endfunction

    // True when the given lane is the last lane of a wide word.
    function automatic logic lane_is_last(input lane_idx_t lane, input int ratio);
        return lane == lane_idx_t'(ratio - 1);
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Output holding register with AXI-Stream valid/ready: loads a completed word,
// holds it stable under backpressure and drops valid after the handshake.
module axis_out_reg
    import axis_width_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BW     = 4,
    parameter int ID_W   = 1,
    parameter int DEST_W = 1,
    parameter int USER_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [BW-1:0]     load_strb,
    input  logic [BW-1:0]     load_keep,
    input  logic              load_last,
    input  logic [ID_W-1:0]   load_id,
    input  logic [DEST_W-1:0] load_dest,
    input  logic [USER_W-1:0] load_user,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic [BW-1:0]     m_strb,
    output logic [BW-1:0]     m_keep,
    output logic              m_last,
    output logic [ID_W-1:0]   m_id,
    output logic [DEST_W-1:0] m_dest,
    output logic [USER_W-1:0] m_user
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [BW-1:0]     strb_q, strb_d;
    logic [BW-1:0]     keep_q, keep_d;
    logic              last_q, last_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [USER_W-1:0] user_q, user_d;

    // Load has priority so a handshake and a new word in one cycle leave no bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        strb_d  = strb_q;
        keep_d  = keep_q;
        last_d  = last_q;
        id_d    = id_q;
        dest_d  = dest_q;
        user_d  = user_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            strb_d  = load_strb;
            keep_d  = load_keep;
            last_d  = load_last;
            id_d    = load_id;
            dest_d  = load_dest;
            user_d  = load_user;
        end else if (m_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= OUT_VALID_RST;
            data_q  <= {DATA_W{OUT_FIELD_RST}};
            strb_q  <= {BW{OUT_FIELD_RST}};
            keep_q  <= {BW{OUT_FIELD_RST}};
            last_q  <= OUT_FIELD_RST;
            id_q    <= {ID_W{OUT_FIELD_RST}};
            dest_q  <= {DEST_W{OUT_FIELD_RST}};
            user_q  <= {USER_W{OUT_FIELD_RST}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            id_q    <= id_d;
            dest_q  <= dest_d;
            user_q  <= user_d;
        end
    end

    assign m_valid = valid_q;
    assign m_data  = data_q;
    assign m_strb  = strb_q;
    assign m_keep  = keep_q;
    assign m_last  = last_q;
    assign m_id    = id_q;
    assign m_dest  = dest_q;
    assign m_user  = user_q;

endmodule

// File: rtl/axis_width_upsizer.sv
// AXI-Stream width upsizer: packs RATIO narrow beats into one wide word,
// lane 0 first, flushing early on tlast, and counts completed output packets.
module axis_width_upsizer
    import axis_width_pkg::*;
#(
    parameter int S_DATA_W = 8,
    parameter int RATIO    = 4,
    parameter int ID_W     = 1,
    parameter int DEST_W   = 1,
    parameter int USER_W   = 1
) (
    input  logic                                      axis_clk,
    input  logic                                      axis_rst_n,
    input  logic                                      s_axis_tvalid,
    output logic                                      s_axis_tready,
    input  logic [S_DATA_W-1:0]                       s_axis_tdata,
    input  logic [S_DATA_W/8-1:0]                     s_axis_tstrb,
    input  logic [S_DATA_W/8-1:0]                     s_axis_tkeep,
    input  logic                                      s_axis_tlast,
    input  logic [ID_W-1:0]                           s_axis_tid,
    input  logic [DEST_W-1:0]                         s_axis_tdest,
    input  logic [USER_W-1:0]                         s_axis_tuser,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic [calc_m_data_w(S_DATA_W, RATIO)-1:0] m_axis_tdata,
    output logic [calc_m_bw(S_DATA_W, RATIO)-1:0]     m_axis_tstrb,
    output logic [calc_m_bw(S_DATA_W, RATIO)-1:0]     m_axis_tkeep,
    output logic                                      m_axis_tlast,
    output logic [ID_W-1:0]                           m_axis_tid,
    output logic [DEST_W-1:0]                         m_axis_tdest,
    output logic [USER_W-1:0]                         m_axis_tuser,
    output logic [15:0]                               pkt_cnt
);

    localparam int M_DATA_W = calc_m_data_w(S_DATA_W, RATIO);
    localparam int M_BW     = calc_m_bw(S_DATA_W, RATIO);
    localparam int S_BW     = S_DATA_W / 8;
    localparam int LANE_W   = $clog2(RATIO);

    logic [LANE_W-1:0]   lane_cnt_q, lane_cnt_d;
    logic [M_DATA_W-1:0] data_acc_q, data_acc_d;
    logic [M_BW-1:0]     keep_acc_q, keep_acc_d;
    logic [M_BW-1:0]     strb_acc_q, strb_acc_d;
    logic [USER_W-1:0]   user_acc_q, user_acc_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DEST_W-1:0]   dest_q, dest_d;
    logic [15:0]         pkt_cnt_q, pkt_cnt_d;

    logic [RATIO-1:0]    lane_hit;
    logic [M_DATA_W-1:0] word_data;
    logic [M_BW-1:0]     word_keep;
    logic [M_BW-1:0]     word_strb;
    logic [USER_W-1:0]   word_user;
    logic [ID_W-1:0]     word_id;
    logic [DEST_W-1:0]   word_dest;
    logic                accept;
    logic                complete;

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign complete      = accept &&
                           (lane_is_last(lane_idx_t'(lane_cnt_q), RATIO) || s_axis_tlast);

    // Word as it would look with the current beat merged into its lane; lanes
    // above the current one are still zero because the accumulator clears on completion.
    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            assign lane_hit[gi] = (lane_cnt_q == LANE_W'(gi));
            assign word_data[gi*S_DATA_W +: S_DATA_W] =
                lane_hit[gi] ? s_axis_tdata : data_acc_q[gi*S_DATA_W +: S_DATA_W];
            assign word_keep[gi*S_BW +: S_BW] =
                lane_hit[gi] ? s_axis_tkeep : keep_acc_q[gi*S_BW +: S_BW];
            assign word_strb[gi*S_BW +: S_BW] =
                lane_hit[gi] ? s_axis_tstrb : strb_acc_q[gi*S_BW +: S_BW];
        end
    endgenerate

    // Routing fields come from the lane-0 beat; tuser is ORed across the word.
    assign word_id   = lane_hit[0] ? s_axis_tid   : id_q;
    assign word_dest = lane_hit[0] ? s_axis_tdest : dest_q;
    assign word_user = user_acc_q | s_axis_tuser;

    // Lane accumulation: store the merged word until it completes, then start empty.
    always_comb begin
        lane_cnt_d = lane_cnt_q;
        data_acc_d = data_acc_q;
        keep_acc_d = keep_acc_q;
        strb_acc_d = strb_acc_q;
        user_acc_d = user_acc_q;
        id_d       = id_q;
        dest_d     = dest_q;
        if (accept) begin
            id_d   = word_id;
            dest_d = word_dest;
            if (complete) begin
                lane_cnt_d = '0;
                data_acc_d = '0;
                keep_acc_d = '0;
                strb_acc_d = '0;
                user_acc_d = '0;
            end else begin
                lane_cnt_d = lane_cnt_q + LANE_W'(1);
                data_acc_d = word_data;
                keep_acc_d = word_keep;
                strb_acc_d = word_strb;
                user_acc_d = word_user;
            end
        end
    end

    // Count packets as their last word leaves the block.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    // Accumulator and counter state.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            lane_cnt_q <= '0;
            data_acc_q <= '0;
            keep_acc_q <= '0;
            strb_acc_q <= '0;
            user_acc_q <= '0;
            id_q       <= '0;
            dest_q     <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            data_acc_q <= data_acc_d;
            keep_acc_q <= keep_acc_d;
            strb_acc_q <= strb_acc_d;
            user_acc_q <= user_acc_d;
            id_q       <= id_d;
            dest_q     <= dest_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;

    axis_out_reg #(
        .DATA_W (M_DATA_W),
        .BW     (M_BW),
        .ID_W   (ID_W),
        .DEST_W (DEST_W),
        .USER_W (USER_W)
    ) u_out_reg (
        .clk       (axis_clk),
        .rst_n     (axis_rst_n),
        .load      (complete),
        .load_data (word_data),
        .load_strb (word_strb),
        .load_keep (word_keep),
        .load_last (s_axis_tlast),
        .load_id   (word_id),
        .load_dest (word_dest),
        .load_user (word_user),
        .m_ready   (m_axis_tready),
        .m_valid   (m_axis_tvalid),
        .m_data    (m_axis_tdata),
        .m_strb    (m_axis_tstrb),
        .m_keep    (m_axis_tkeep),
        .m_last    (m_axis_tlast),
        .m_id      (m_axis_tid),
        .m_dest    (m_axis_tdest),
        .m_user    (m_axis_tuser)
    );

endmodule

// File: tb/tb_axis_width_upsizer.sv
// Directed bench for axis_width_upsizer (8-bit in, 4 lanes): expected words are
// queued when a packet is driven and compared as each output handshake occurs.
module tb_axis_width_upsizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic [0:0]  s_strb;
    logic [0:0]  s_keep;
    logic        s_last;
    logic [0:0]  s_id;
    logic [0:0]  s_dest;
    logic [0:0]  s_user;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_strb;
    logic [3:0]  m_keep;
    logic        m_last;
    logic [0:0]  m_id;
    logic [0:0]  m_dest;
    logic [0:0]  m_user;
    logic [15:0] pkt_cnt;

    int   checks   = 0;
    int   failures = 0;
    logic toggle_mode = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic [3:0]  strb;
        logic        last;
        logic        user;
        logic        id;
        logic        dest;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    axis_width_upsizer dut (
        .axis_clk      (clk),
        .axis_rst_n    (rst_n),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .s_axis_tdata  (s_data),
        .s_axis_tstrb  (s_strb),
        .s_axis_tkeep  (s_keep),
        .s_axis_tlast  (s_last),
        .s_axis_tid    (s_id),
        .s_axis_tdest  (s_dest),
        .s_axis_tuser  (s_user),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tstrb  (m_strb),
        .m_axis_tkeep  (m_keep),
        .m_axis_tlast  (m_last),
        .m_axis_tid    (m_id),
        .m_axis_tdest  (m_dest),
        .m_axis_tuser  (m_user),
        .pkt_cnt       (pkt_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] data, input logic [3:0] keep,
                            input logic [3:0] strb, input logic last,
                            input logic user, input logic id, input logic dest);
        exp_t e;
        e.data = data; e.keep = keep; e.strb = strb; e.last = last;
        e.user = user; e.id = id; e.dest = dest;
        exp_q.push_back(e);
    endtask

    // Expected words for a packet of len bytes base, base+1, ...
    task automatic push_packet(input int base, input int len,
                               input logic user, input logic id, input logic dest);
        exp_t e;
        for (int w = 0; w * 4 < len; w++) begin
            e.data = '0;
            e.keep = '0;
            for (int l = 0; l < 4 && (w * 4 + l) < len; l++) begin
                e.data[l*8 +: 8] = 8'(base + w * 4 + l);
                e.keep[l] = 1'b1;
            end
            e.strb = e.keep;
            e.last = ((w * 4 + 4) >= len);
            e.user = user; e.id = id; e.dest = dest;
            exp_q.push_back(e);
        end
    endtask

    // Compare one output word against the head of the scoreboard.
    task automatic check_out();
        exp_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_word observed=0x%08h expected=none", m_data);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            $display("word out data=0x%08h keep=%h strb=%h last=%0d user=%0d id=%0d dest=%0d",
                     m_data, m_keep, m_strb, m_last, m_user, m_id, m_dest);
            chk("m_tdata", m_data, e.data);
            chk("m_tkeep", 32'(m_keep), 32'(e.keep));
            chk("m_tstrb", 32'(m_strb), 32'(e.strb));
            chk("m_tlast", 32'(m_last), 32'(e.last));
            chk("m_tuser", 32'(m_user), 32'(e.user));
            chk("m_tid",   32'(m_id),   32'(e.id));
            chk("m_tdest", 32'(m_dest), 32'(e.dest));
        end
    endtask

    // One clock: sample at the falling edge, advance past the rising edge.
    task automatic tick(output logic acc);
        @(negedge clk);
        acc = s_valid && s_ready;
        if (m_valid && m_ready) check_out();
        @(posedge clk);
        #1;
        if (toggle_mode) m_ready = ~m_ready;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last,
                             input logic user, input logic id, input logic dest);
        logic acc;
        int   n;
        s_valid = 1'b1; s_data = d; s_keep = 1'b1; s_strb = 1'b1;
        s_last = last; s_user = user; s_id = id; s_dest = dest;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            tick(acc);
            n++;
        end
        chk("beat_accept", 32'(acc), 32'd1);
        s_valid = 1'b0;
    endtask

    task automatic send_packet(input int base, input int first, input int count, input int len,
                               input logic user, input logic id, input logic dest);
        for (int i = first; i < first + count; i++) begin
            send_beat(8'(base + i), (i == len - 1), user, id, dest);
        end
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 500) begin
            tick(acc);
            n++;
        end
        chk("drain_done", 32'(exp_q.size() == 0 && !m_valid), 32'd1);
    endtask

    initial begin
        int base;
        int lens[9] = '{5, 7, 4, 16, 1, 3, 12, 9, 7};

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_strb = '0; s_keep = '0;
        s_last = 1'b0; s_id = '0; s_dest = '0; s_user = '0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        chk("rst_m_tvalid", 32'(m_valid), 32'd0);
        chk("rst_m_tdata",  m_data, 32'd0);
        chk("rst_m_tkeep",  32'(m_keep), 32'd0);
        chk("rst_m_tstrb",  32'(m_strb), 32'd0);
        chk("rst_m_tlast",  32'(m_last), 32'd0);
        chk("rst_sideband", 32'({m_id, m_dest, m_user}), 32'd0);
        chk("rst_pkt_cnt",  32'(pkt_cnt), 32'd0);
        chk("rst_s_tready", 32'(s_ready), 32'd1);

        // Full packet: two complete words
        push_exp(32'h03020100, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(32'h07060504, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        send_packet(8'h00, 0, 8, 8, 1'b0, 1'b0, 1'b0);
        drain();
        chk("pkt_cnt_full", 32'(pkt_cnt), 32'd1);

        // Partial flush on tlast
        push_exp(32'h13121110, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(32'h00001514, 4'h3, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
        send_packet(8'h10, 0, 6, 6, 1'b0, 1'b0, 1'b0);
        drain();
        chk("pkt_cnt_partial", 32'(pkt_cnt), 32'd2);

        // Single-beat packet with sideband set; word visible right after acceptance
        push_exp(32'h000000AA, 4'h1, 4'h1, 1'b1, 1'b1, 1'b1, 1'b1);
        send_beat(8'hAA, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("single_latency_valid", 32'(m_valid), 32'd1);
        chk("single_latency_data",  m_data, 32'h000000AA);
        drain();
        chk("pkt_cnt_single", 32'(pkt_cnt), 32'd3);

        // Backpressure: first word held, input stalled, then 16 beats flow out as 4 words
        m_ready = 1'b0;
        push_packet(8'h30, 16, 1'b0, 1'b0, 1'b0);
        send_packet(8'h30, 0, 4, 16, 1'b0, 1'b0, 1'b0);
        s_valid = 1'b1; s_data = 8'h34; s_keep = 1'b1; s_strb = 1'b1; s_last = 1'b0;
        s_user = 1'b0; s_id = 1'b0; s_dest = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_s_tready", 32'(s_ready), 32'd0);
            chk("bp_m_tvalid", 32'(m_valid), 32'd1);
            chk("bp_hold_data", m_data, 32'h33323130);
            chk("bp_hold_keep", 32'(m_keep), 32'hF);
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        send_packet(8'h30, 4, 12, 16, 1'b0, 1'b0, 1'b0);
        drain();
        chk("pkt_cnt_bp", 32'(pkt_cnt), 32'd4);

        // Reset mid-packet: partial word discarded, next packet starts at lane 0
        send_packet(8'h50, 0, 2, 4, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_m_tvalid", 32'(m_valid), 32'd0);
        chk("midrst_m_tdata",  m_data, 32'd0);
        chk("midrst_m_tkeep",  32'(m_keep), 32'd0);
        chk("midrst_m_tlast",  32'(m_last), 32'd0);
        chk("midrst_pkt_cnt",  32'(pkt_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(32'h23222120, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        send_packet(8'h20, 0, 4, 4, 1'b0, 1'b0, 1'b0);
        drain();
        chk("pkt_cnt_after_rst", 32'(pkt_cnt), 32'd1);

        // Streaming 64 beats in 9 packets with downstream ready toggling every cycle
        toggle_mode = 1'b1;
        base = 8'h60;
        foreach (lens[k]) begin
            push_packet(base, lens[k], 1'b0, 1'b0, 1'b0);
            send_packet(base, 0, lens[k], lens[k], 1'b0, 1'b0, 1'b0);
            base += lens[k];
        end
        drain();
        toggle_mode = 1'b0;
        m_ready = 1'b1;
        chk("pkt_cnt_stream", 32'(pkt_cnt), 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
